uart_apb_sequencer: RTL and testbench

UART_APB_SEQUENCER -- requirements
Module: uart_apb_sequencer

---
 rtl/uart_apb_sequencer.sv | 268 ++++++++++++++++++++++++++
 tb/tb_uart_apb_sequencer.sv | 470 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_apb_sequencer.sv
// ---------------------------------------------------------------------------
// uart_apb_sequencer
//
// APB master that sequences accesses to a UART register block:
//   - configuration: writes ControlReg1 (0x04) then ControlReg0 (0x03)
//   - RX service:    reads the RX data register (0x01) after an irqreq pulse
//   - TX service:    reads status (0x05); if the UDRE bit is set, writes the
//                    granted requester's byte to the TX register (0x00)
// Two TX requesters are arbitrated round-robin. Every APB transfer is a
// two-cycle SETUP/ACCESS pair with no wait states.
//
// Optional feature macro: UART_SEQ_RX_EN
//   defined   -> RX path present (rx_pend, RXR state, rx_valid, rx_data)
//   undefined -> irqreq ignored, rx_valid/rx_data held at 0
//
// Parameters
//   UDRE_BIT   status-register bit that permits a TX write (default 2)
//
// Ports
//   PCLK, PRESETn            clock, async active-low reset
//   cfg_cr0, cfg_cr1         control register values to program
//   cfg_start                pulse: request a configuration sequence
//   reqN_valid/data/ready    TX requester N handshake (ready = 1-cycle pulse)
//   irqreq                   RX-complete pulse from the UART register block
//   rx_valid, rx_data        1-cycle pulse with the last received byte
//   PSEL..PWDATA, PRDATA     APB master interface
//   busy                     high whenever the FSM is not in IDLE
//   tx_count                 wrapping count of TX bytes written
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no transfer; APB outputs 0; picks the next job by priority
// CFG1  | write 0x04 <= cfg_cr1
// CFG0  | write 0x03 <= cfg_cr0
// RXR   | read 0x01, capture rx_data
// POLL  | read 0x05, check UDRE bit
// TXW   | write 0x00 <= granted TX byte, pulse granted ready
// ---------------------------------------------------------------------------
module uart_apb_sequencer #(
  parameter int unsigned UDRE_BIT = 2
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic [7:0]  cfg_cr0,
  input  logic [7:0]  cfg_cr1,
  input  logic        cfg_start,
  input  logic        req0_valid,
  input  logic [7:0]  req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_data,
  output logic        req1_ready,
  input  logic        irqreq,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  output logic        busy,
  output logic [15:0] tx_count
);

  localparam logic [4:0] UDRE_IDX = UDRE_BIT[4:0];

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CFG1 = 3'd1,
    S_CFG0 = 3'd2,
    S_RXR  = 3'd3,
    S_POLL = 3'd4,
    S_TXW  = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic        access_q, access_d;   // 0 = SETUP phase, 1 = ACCESS phase

  logic        cfg_pend_q, cfg_pend_d;
  logic        cfg_done_q, cfg_done_d;
  logic        rr_ptr_q, rr_ptr_d;
  logic        gnt_q, gnt_d;         // 0 = requester 0, 1 = requester 1
  logic [7:0]  txd_q, txd_d;
  logic [7:0]  hold_q, hold_d;       // config byte captured in SETUP
  logic [15:0] tx_count_q, tx_count_d;

  logic        cfg_req;
  logic        rx_req;
  logic        any_valid;
  logic        pick1;
  logic        enter_cfg1;
  logic        enter_poll;
  logic        txw_access;
  logic        cfg0_access;

  // Pending flags are OR-ed with their live pulse so a request arriving
  // while IDLE is served in that same decision cycle.
  assign cfg_req   = cfg_pend_q | cfg_start;
  assign any_valid = req0_valid | req1_valid;
  // both valid: rr_ptr decides; otherwise whichever one is valid
  assign pick1     = (req0_valid && req1_valid) ? rr_ptr_q : req1_valid;

  // -------------------------------------------------------------------------
  // state register
  // -------------------------------------------------------------------------
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= S_IDLE;
      access_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      access_q <= access_d;
    end
  end

  // -------------------------------------------------------------------------
  // next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    access_d = 1'b0;
    if (state_q == S_IDLE) begin
      if (cfg_req)                        state_d = S_CFG1;
      else if (rx_req)                    state_d = S_RXR;
      else if (cfg_done_q && any_valid)   state_d = S_POLL;
    end else if (!access_q) begin
      access_d = 1'b1;
    end else begin
      case (state_q)
        S_CFG1:  state_d = S_CFG0;
        S_POLL:  state_d = PRDATA[UDRE_IDX] ? S_TXW : S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // output logic
  // -------------------------------------------------------------------------
  always_comb begin
    PSEL       = 1'b0;
    PENABLE    = 1'b0;
    PWRITE     = 1'b0;
    PADDR      = 32'd0;
    PWDATA     = 32'd0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    busy       = (state_q != S_IDLE);
    if (state_q != S_IDLE) begin
      PSEL    = 1'b1;
      PENABLE = access_q;
    end
    case (state_q)
      S_CFG1: begin
        PWRITE = 1'b1;
        PADDR  = 32'h0000_0004;
        PWDATA = {24'd0, access_q ? hold_q : cfg_cr1};
      end
      S_CFG0: begin
        PWRITE = 1'b1;
        PADDR  = 32'h0000_0003;
        PWDATA = {24'd0, access_q ? hold_q : cfg_cr0};
      end
      S_RXR:  PADDR = 32'h0000_0001;
      S_POLL: PADDR = 32'h0000_0005;
      S_TXW: begin
        PWRITE     = 1'b1;
        PADDR      = 32'h0000_0000;
        PWDATA     = {24'd0, txd_q};
        req0_ready = access_q & ~gnt_q;
        req1_ready = access_q & gnt_q;
      end
      default: ;
    endcase
  end

  assign tx_count = tx_count_q;

  // -------------------------------------------------------------------------
  // datapath / bookkeeping registers
  // -------------------------------------------------------------------------
  assign enter_cfg1  = (state_q == S_IDLE) && (state_d == S_CFG1);
  assign enter_poll  = (state_q == S_IDLE) && (state_d == S_POLL);
  assign txw_access  = (state_q == S_TXW)  && access_q;
  assign cfg0_access = (state_q == S_CFG0) && access_q;

  always_comb begin
    // a cfg_start during any transfer is simply remembered until IDLE
    cfg_pend_d = (cfg_pend_q | cfg_start) & ~enter_cfg1;
    cfg_done_d = cfg_done_q | cfg0_access;
    rr_ptr_d   = rr_ptr_q ^ txw_access;
    // grant and byte are frozen at IDLE->POLL, so a requester that drops
    // valid early still gets its latched byte written
    gnt_d      = enter_poll ? pick1 : gnt_q;
    txd_d      = enter_poll ? (pick1 ? req1_data : req0_data) : txd_q;
    tx_count_d = tx_count_q + {15'd0, txw_access};
    hold_d     = hold_q;
    if (!access_q) begin
      if (state_q == S_CFG1)      hold_d = cfg_cr1;
      else if (state_q == S_CFG0) hold_d = cfg_cr0;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cfg_pend_q <= 1'b0;
      cfg_done_q <= 1'b0;
      rr_ptr_q   <= 1'b0;
      gnt_q      <= 1'b0;
      txd_q      <= 8'd0;
      hold_q     <= 8'd0;
      tx_count_q <= 16'd0;
    end else begin
      cfg_pend_q <= cfg_pend_d;
      cfg_done_q <= cfg_done_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_q      <= gnt_d;
      txd_q      <= txd_d;
      hold_q     <= hold_d;
      tx_count_q <= tx_count_d;
    end
  end

  // -------------------------------------------------------------------------
  // RX path
  // -------------------------------------------------------------------------
`ifdef UART_SEQ_RX_EN
  logic       rx_pend_q, rx_pend_d;
  logic       rx_valid_q, rx_valid_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rxr_access;

  assign rxr_access = (state_q == S_RXR) && access_q;
  assign rx_req     = rx_pend_q | irqreq;

  always_comb begin
    // an irqreq landing in the RXR ACCESS cycle re-arms the flag
    rx_pend_d  = irqreq | (rx_pend_q & ~rxr_access);
    rx_valid_d = rxr_access;
    rx_data_d  = rxr_access ? PRDATA[7:0] : rx_data_q;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rx_pend_q  <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= 8'd0;
    end else begin
      rx_pend_q  <= rx_pend_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
    end
  end

  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
`else
  assign rx_req   = 1'b0;
  assign rx_valid = 1'b0;
  assign rx_data  = 8'd0;
`endif

  // inputs (or bits of them) that only feed the optional RX path
  logic unused_inputs;
  assign unused_inputs = ^{irqreq, PRDATA};

endmodule

// File: tb/tb_uart_apb_sequencer.sv
`timescale 1ns/1ps
module tb_uart_apb_sequencer;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic [7:0]  cfg_cr0 = 8'd0;
  logic [7:0]  cfg_cr1 = 8'd0;
  logic        cfg_start = 1'b0;
  logic        req0_valid = 1'b0;
  logic [7:0]  req0_data = 8'd0;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [7:0]  req1_data = 8'd0;
  logic        req1_ready;
  logic        irqreq = 1'b0;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        busy;
  logic [15:0] tx_count;

  logic [7:0]  status_byte = 8'd0;
  logic [7:0]  rx_byte = 8'd0;

  int n_checks = 0;
  int n_errors = 0;
  logic mon_en = 1'b0;

  uart_apb_sequencer #(.UDRE_BIT(2)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cfg_cr0(cfg_cr0), .cfg_cr1(cfg_cr1), .cfg_start(cfg_start),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .irqreq(irqreq), .rx_valid(rx_valid), .rx_data(rx_data),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .busy(busy), .tx_count(tx_count)
  );

  always #5 PCLK = ~PCLK;

  // UART register block model: status at 0x05, RX data at 0x01
  assign PRDATA = (PSEL && PENABLE && PADDR == 32'h5) ? {24'd0, status_byte} :
                  (PSEL && PENABLE && PADDR == 32'h1) ? {24'd0, rx_byte} : 32'd0;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic        rdy0;
    logic        rdy1;
  } xfer_t;

  xfer_t exp_q[$];
  xfer_t e;

  function automatic xfer_t mk(input logic wr, input logic [31:0] addr,
                               input logic [31:0] data, input logic r0, input logic r1);
    xfer_t x;
    x.wr = wr; x.addr = addr; x.data = data; x.rdy0 = r0; x.rdy1 = r1;
    return x;
  endfunction

  // APB monitor / scoreboard: pops one expectation per ACCESS cycle
  logic        prev_setup = 1'b0;
  logic [31:0] prev_addr = 32'd0;
  always @(negedge PCLK) begin
    if (mon_en) begin
      if (PSEL === 1'b1 && PENABLE === 1'b1) begin
        n_checks++;
        if (!prev_setup || prev_addr !== PADDR) begin
          n_errors++;
          $display("FAIL apb_setup_phase: access addr %h without matching setup (prev setup %b addr %h)",
                   PADDR, prev_setup, prev_addr);
        end
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL apb_unexpected: got wr=%b addr=%h wdata=%h, expected no transfer",
                   PWRITE, PADDR, PWDATA);
        end else begin
          e = exp_q.pop_front();
          if (PWRITE !== e.wr || PADDR !== e.addr || (e.wr && PWDATA !== e.data) ||
              req0_ready !== e.rdy0 || req1_ready !== e.rdy1) begin
            n_errors++;
            $display("FAIL apb_xfer: got wr=%b addr=%h wdata=%h rdy=%b%b, expected wr=%b addr=%h wdata=%h rdy=%b%b",
                     PWRITE, PADDR, PWDATA, req0_ready, req1_ready,
                     e.wr, e.addr, e.data, e.rdy0, e.rdy1);
          end
        end
      end else begin
        n_checks++;
        if ((PSEL !== 1'b1 && (PENABLE !== 1'b0 || PWRITE !== 1'b0 ||
             PADDR !== 32'd0 || PWDATA !== 32'd0)) ||
            req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
          n_errors++;
          $display("FAIL apb_idle_outputs: PSEL=%b PENABLE=%b PWRITE=%b PADDR=%h PWDATA=%h rdy=%b%b, expected all 0",
                   PSEL, PENABLE, PWRITE, PADDR, PWDATA, req0_ready, req1_ready);
        end
      end
      prev_setup = (PSEL === 1'b1 && PENABLE === 1'b0);
      prev_addr  = PADDR;
    end
  end

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic test_reset();
    PRESETn = 1'b0;
    repeat (3) tick();
    mon_en = 1'b1;
    n_checks++;
    if ({PSEL, PENABLE, PWRITE, busy, req0_ready, req1_ready, rx_valid} !== 7'b0) begin
      n_errors++;
      $display("FAIL reset_ctrl: got %b, expected 0000000",
               {PSEL, PENABLE, PWRITE, busy, req0_ready, req1_ready, rx_valid});
    end
    n_checks++;
    if (PADDR !== 32'd0 || PWDATA !== 32'd0) begin
      n_errors++;
      $display("FAIL reset_apb_bus: PADDR=%h PWDATA=%h, expected 0", PADDR, PWDATA);
    end
    n_checks++;
    if (tx_count !== 16'd0 || rx_data !== 8'd0) begin
      n_errors++;
      $display("FAIL reset_counters: tx_count=%h rx_data=%h, expected 0", tx_count, rx_data);
    end
    PRESETn = 1'b1;
    tick();
  endtask

  task automatic test_no_tx_before_cfg();
    status_byte = 8'h04;
    req0_valid = 1'b1;
    req0_data  = 8'h99;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++;
      if (PSEL !== 1'b0 || busy !== 1'b0) begin
        n_errors++;
        $display("FAIL no_tx_before_cfg: PSEL=%b busy=%b at cycle %0d, expected 0", PSEL, busy, i);
      end
    end
    req0_valid = 1'b0;
    tick();
  endtask

  task automatic test_config();
    cfg_cr1 = 8'h1B;
    cfg_cr0 = 8'h77;   // replaced before CFG0 SETUP; must not be the value written
    exp_q.push_back(mk(1'b1, 32'h4, 32'h1B, 1'b0, 1'b0));
    exp_q.push_back(mk(1'b1, 32'h3, 32'h03, 1'b0, 1'b0));
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    for (int i = 0; i < 8 && PSEL !== 1'b1; i++) tick();
    n_checks++;
    if (PSEL !== 1'b1) begin
      n_errors++;
      $display("FAIL cfg_start_timeout: PSEL=%b, expected 1 within 8 cycles", PSEL);
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (PSEL !== 1'b1 || busy !== 1'b1 || PENABLE !== k[0] ||
          PADDR !== ((k < 2) ? 32'h4 : 32'h3)) begin
        n_errors++;
        $display("FAIL cfg_sequence: cycle %0d PSEL=%b busy=%b PENABLE=%b PADDR=%h, expected 1 1 %b %h",
                 k, PSEL, busy, PENABLE, PADDR, k[0], (k < 2) ? 32'h4 : 32'h3);
      end
      if (k == 0) begin
        n_checks++;
        if (PWDATA !== 32'h1B) begin
          n_errors++;
          $display("FAIL cfg1_setup_data: PWDATA=%h, expected 0000001b", PWDATA);
        end
      end
      if (k == 1) cfg_cr0 = 8'h03;
      if (k == 3) begin
        cfg_cr0 = 8'hEE;
        cfg_cr1 = 8'hEE;
      end
      tick();
    end
    n_checks++;
    if (busy !== 1'b0 || PSEL !== 1'b0 || exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL cfg_end: busy=%b PSEL=%b pending=%0d, expected 0 0 0", busy, PSEL, exp_q.size());
    end
    tick();
  endtask

  task automatic test_tx_both();
    logic got0, got1;
    int t0, t1;
    logic [15:0] cnt;
    got0 = 1'b0; got1 = 1'b0; t0 = 0; t1 = 0;
    cnt = tx_count;
    status_byte = 8'h04;
    exp_q.push_back(mk(1'b0, 32'h5, 32'h0, 1'b0, 1'b0));
    exp_q.push_back(mk(1'b1, 32'h0, 32'hA5, 1'b1, 1'b0));
    exp_q.push_back(mk(1'b0, 32'h5, 32'h0, 1'b0, 1'b0));
    exp_q.push_back(mk(1'b1, 32'h0, 32'h5A, 1'b0, 1'b1));
    req0_valid = 1'b1; req0_data = 8'hA5;
    req1_valid = 1'b1; req1_data = 8'h5A;
    for (int c = 0; c < 40 && !(got0 && got1); c++) begin
      tick();
      if (req0_ready === 1'b1 && !got0) begin got0 = 1'b1; t0 = c; req0_valid = 1'b0; end
      if (req1_ready === 1'b1 && !got1) begin got1 = 1'b1; t1 = c; req1_valid = 1'b0; end
    end
    n_checks++;
    if (!(got0 && got1)) begin
      n_errors++;
      $display("FAIL tx_both_timeout: ready0 seen=%b ready1 seen=%b, expected both", got0, got1);
    end
    n_checks++;
    if (t1 - t0 != 5) begin
      n_errors++;
      $display("FAIL tx_spacing: ready1-ready0 = %0d cycles, expected 5", t1 - t0);
    end
    tick();
    n_checks++;
    if (tx_count !== cnt + 16'd2 || exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL tx_both_count: tx_count=%h pending=%0d, expected %h 0", tx_count, exp_q.size(), cnt + 16'd2);
    end
  endtask

  task automatic test_poll_wait();
    int polls;
    logic changed, got;
    logic [15:0] cnt;
    polls = 0; changed = 1'b0; got = 1'b0;
    cnt = tx_count;
    status_byte = 8'hFB;   // every bit except UDRE
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(1'b0, 32'h5, 32'h0, 1'b0, 1'b0));
    req0_valid = 1'b1; req0_data = 8'h11;
    for (int c = 0; c < 80 && !got; c++) begin
      tick();
      if (PSEL === 1'b1 && PENABLE === 1'b1 && PADDR === 32'h5) polls++;
      if (!changed && polls == 3 && PSEL === 1'b0) begin
        status_byte = 8'h04;
        changed = 1'b1;
        exp_q.push_back(mk(1'b0, 32'h5, 32'h0, 1'b0, 1'b0));
        exp_q.push_back(mk(1'b1, 32'h0, 32'h11, 1'b1, 1'b0));
      end
      if (req0_ready === 1'b1) begin
        got = 1'b1;
        req0_valid = 1'b0;
        n_checks++;
        if (!changed) begin
          n_errors++;
          $display("FAIL poll_early_tx: ready seen after %0d polls with UDRE=0, expected none", polls);
        end
      end
    end
    tick();
    n_checks++;
    if (!got || polls != 4) begin
      n_errors++;
      $display("FAIL poll_wait: ready seen=%b polls=%0d, expected 1 and 4", got, polls);
    end
    n_checks++;
    if (tx_count !== cnt + 16'd1 || exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL poll_wait_count: tx_count=%h pending=%0d, expected %h 0", tx_count, exp_q.size(), cnt + 16'd1);
    end
  endtask

`ifdef UART_SEQ_RX_EN
  task automatic test_rx();
    int n_rx;
    logic chk_pulse, chk_low, got;
    logic [7:0] exp_byte;
    logic [15:0] cnt;
    n_rx = 0; chk_pulse = 1'b0; chk_low = 1'b0; got = 1'b0; exp_byte = 8'h3C;
    cnt = tx_count;
    status_byte = 8'h04;
    rx_byte = 8'h3C;
    exp_q.push_back(mk(1'b0, 32'h1, 32'h0, 1'b0, 1'b0));
    exp_q.push_back(mk(1'b0, 32'h1, 32'h0, 1'b0, 1'b0));
    exp_q.push_back(mk(1'b0, 32'h5, 32'h0, 1'b0, 1'b0));
    exp_q.push_back(mk(1'b1, 32'h0, 32'h77, 1'b1, 1'b0));
    irqreq = 1'b1;
    req0_valid = 1'b1; req0_data = 8'h77;
    tick();
    irqreq = 1'b0;
    for (int c = 0; c < 60 && !got; c++) begin
      if (PSEL === 1'b1 && PENABLE === 1'b1 && PADDR === 32'h1) begin
        n_rx++;
        chk_pulse = 1'b1;
        exp_byte = (n_rx == 1) ? 8'h3C : 8'hC3;
        if (n_rx == 1) irqreq = 1'b1;   // lands in the RXR ACCESS cycle
      end else if (chk_pulse) begin
        n_checks++;
        if (rx_valid !== 1'b1 || rx_data !== exp_byte) begin
          n_errors++;
          $display("FAIL rx_pulse: rx_valid=%b rx_data=%h, expected 1 %h", rx_valid, rx_data, exp_byte);
        end
        chk_pulse = 1'b0;
        chk_low = 1'b1;
        irqreq = 1'b0;
        rx_byte = 8'hC3;
      end else if (chk_low) begin
        n_checks++;
        if (rx_valid !== 1'b0) begin
          n_errors++;
          $display("FAIL rx_pulse_width: rx_valid=%b, expected 0", rx_valid);
        end
        chk_low = 1'b0;
      end
      if (req0_ready === 1'b1) begin got = 1'b1; req0_valid = 1'b0; end
      tick();
    end
    n_checks++;
    if (!got || n_rx != 2) begin
      n_errors++;
      $display("FAIL rx_then_tx: ready seen=%b rx reads=%0d, expected 1 and 2", got, n_rx);
    end
    n_checks++;
    if (tx_count !== cnt + 16'd1 || rx_data !== 8'hC3 || exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL rx_end: tx_count=%h rx_data=%h pending=%0d, expected %h c3 0",
               tx_count, rx_data, exp_q.size(), cnt + 16'd1);
    end
  endtask
`else
  task automatic test_rx_disabled();
    logic got;
    logic [15:0] cnt;
    got = 1'b0;
    cnt = tx_count;
    status_byte = 8'h04;
    rx_byte = 8'h3C;
    exp_q.push_back(mk(1'b0, 32'h5, 32'h0, 1'b0, 1'b0));
    exp_q.push_back(mk(1'b1, 32'h0, 32'h77, 1'b1, 1'b0));
    irqreq = 1'b1;
    req0_valid = 1'b1; req0_data = 8'h77;
    for (int c = 0; c < 40 && !got; c++) begin
      tick();
      irqreq = 1'b0;
      n_checks++;
      if (rx_valid !== 1'b0 || rx_data !== 8'd0) begin
        n_errors++;
        $display("FAIL rx_disabled: rx_valid=%b rx_data=%h, expected 0 00", rx_valid, rx_data);
      end
      if (req0_ready === 1'b1) begin got = 1'b1; req0_valid = 1'b0; end
    end
    tick();
    n_checks++;
    if (!got || tx_count !== cnt + 16'd1 || exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL rx_disabled_tx: ready seen=%b tx_count=%h pending=%0d, expected 1 %h 0",
               got, tx_count, exp_q.size(), cnt + 16'd1);
    end
  endtask
`endif

  task automatic test_cfg_during_tx();
    logic pulsed, done;
    pulsed = 1'b0; done = 1'b0;
    status_byte = 8'h04;
    cfg_cr1 = 8'h2A;
    cfg_cr0 = 8'h55;
    exp_q.push_back(mk(1'b0, 32'h5, 32'h0, 1'b0, 1'b0));
    exp_q.push_back(mk(1'b1, 32'h0, 32'hC7, 1'b0, 1'b1));
    exp_q.push_back(mk(1'b1, 32'h4, 32'h2A, 1'b0, 1'b0));
    exp_q.push_back(mk(1'b1, 32'h3, 32'h55, 1'b0, 1'b0));
    req1_valid = 1'b1; req1_data = 8'hC7;
    for (int c = 0; c < 40 && !done; c++) begin
      tick();
      if (!pulsed && PSEL === 1'b1 && PENABLE === 1'b1 && PWRITE === 1'b1 && PADDR === 32'h0) begin
        cfg_start = 1'b1;
        pulsed = 1'b1;
        n_checks++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
          n_errors++;
          $display("FAIL cfg_during_tx_ready: ready=%b%b, expected 01", req0_ready, req1_ready);
        end
        req1_valid = 1'b0;
      end else if (cfg_start) begin
        cfg_start = 1'b0;
      end
      if (pulsed && !cfg_start && exp_q.size() == 0 && busy === 1'b0) done = 1'b1;
    end
    n_checks++;
    if (!done) begin
      n_errors++;
      $display("FAIL cfg_during_tx_timeout: pulsed=%b pending=%0d, expected 1 0", pulsed, exp_q.size());
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (busy !== 1'b0) begin
        n_errors++;
        $display("FAIL cfg_pend_cleared: busy=%b at idle cycle %0d, expected 0", busy, i);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic found;
    found = 1'b0;
    status_byte = 8'h04;
    exp_q.push_back(mk(1'b0, 32'h5, 32'h0, 1'b0, 1'b0));
    req0_valid = 1'b1; req0_data = 8'h42;
    for (int c = 0; c < 20 && !found; c++) begin
      tick();
      if (PSEL === 1'b1 && PENABLE === 1'b0 && PADDR === 32'h5) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_errors++;
      $display("FAIL reset_mid_no_poll: POLL setup seen=%b, expected 1", found);
    end
    PRESETn = 1'b0;
    #1;
    n_checks++;
    if ({PSEL, PENABLE, PWRITE, busy, req0_ready, req1_ready, rx_valid} !== 7'b0 ||
        PADDR !== 32'd0 || PWDATA !== 32'd0 || tx_count !== 16'd0 || rx_data !== 8'd0) begin
      n_errors++;
      $display("FAIL reset_mid_outputs: ctrl=%b PADDR=%h PWDATA=%h tx_count=%h rx_data=%h, expected all 0",
               {PSEL, PENABLE, PWRITE, busy, req0_ready, req1_ready, rx_valid},
               PADDR, PWDATA, tx_count, rx_data);
    end
    exp_q.delete();
    repeat (2) tick();
    PRESETn = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      n_checks++;
      if (PSEL !== 1'b0 || req0_ready !== 1'b0 || busy !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_mid_quiet: PSEL=%b ready0=%b busy=%b at cycle %0d, expected 0",
                 PSEL, req0_ready, busy, i);
      end
    end
    req0_valid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_no_tx_before_cfg();
    test_config();
    test_tx_both();
    test_poll_wait();
`ifdef UART_SEQ_RX_EN
    test_rx();
`else
    test_rx_disabled();
`endif
    test_cfg_during_tx();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    n_errors++;
    $display("FAIL watchdog: simulation did not complete within 200000 ns");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
